rsi_signal_gen: RTL and testbench

RSI_SIGNAL_GEN -- requirements
Module: rsi_signal_gen

---
 rtl/rsi_pkg.sv | 45 ++++
 rtl/rsi_evt_queue.sv | 87 ++++++++
 rtl/rsi_signal_gen.sv | 169 ++++++++++++++++
 tb/tb_rsi_signal_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsi_pkg.sv
// Shared definitions for the RSI signal generator: zone and event encodings,
// FSM states, default thresholds and the sample clamp helper.
package rsi_pkg;

    localparam int unsigned DEF_OB_TH   = 70;
    localparam int unsigned DEF_OS_TH   = 30;
    localparam int unsigned DEF_HYST    = 5;
    localparam int unsigned DEF_CONFIRM = 2;
    localparam int unsigned DEF_QDEPTH  = 4;

    localparam int unsigned RSI_MAX = 100;
    localparam int unsigned EVT_W   = 10;

    typedef enum logic [1:0] {
        ZONE_NEUTRAL    = 2'b00,
        ZONE_OVERSOLD   = 2'b01,
        ZONE_OVERBOUGHT = 2'b10
    } zone_e;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_BUY  = 2'b01,
        EVT_SELL = 2'b10
    } evt_code_e;

    typedef enum logic [2:0] {
        ST_NEUTRAL,
        ST_OS_PEND,
        ST_OVERSOLD,
        ST_OB_PEND,
        ST_OVERBOUGHT
    } state_e;

    // Queue entry: event code in the upper two bits, triggering sample below.
    typedef struct packed {
        evt_code_e  code;
        logic [7:0] rsi;
    } evt_t;

    // RSI is a percentage; anything above 100 from the engine is saturated.
    function automatic logic [7:0] clamp_rsi(input logic [7:0] raw);
        return (raw > 8'(RSI_MAX)) ? 8'(RSI_MAX) : raw;
    endfunction

endpackage

// File: rtl/rsi_evt_queue.sv
// Event FIFO with a registered head. A push into an empty queue is visible
// at the head on the same edge; a push while full is dropped (sticky
// overflow) unless the head is popped in that same cycle.
module rsi_evt_queue
    import rsi_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_QDEPTH,
    parameter int unsigned W     = EVT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          full, do_push, do_pop;

    // Accept/reject decisions and next pointer/occupancy values.
    always_comb begin
        full       = (count == FULL_CNT);
        do_pop     = pop && head_valid;
        do_push    = push && (!full || do_pop);
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_push)
            wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        if (do_pop)
            rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        if (do_push && !do_pop)
            count_nxt = count + CW'(1);
        else if (!do_push && do_pop)
            count_nxt = count - CW'(1);
    end

    // Storage write port.
    // NOTE: the payload array carries no reset; occupancy and the head register
    // define what is valid, so resetting the RAM would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers, occupancy, sticky overflow and the registered head.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (push && !do_push)
                overflow <= 1'b1;
            if (count_nxt == '0) begin
                head_valid <= 1'b0;
                head_data  <= '0;
            end else if (do_push && rd_ptr_nxt == wr_ptr) begin
                // The new head is the entry being written on this very edge.
                head_valid <= 1'b1;
                head_data  <= push_data;
            end else begin
                head_valid <= 1'b1;
                head_data  <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/rsi_signal_gen.sv
// RSI zone tracker: clamps incoming RSI samples, confirms zone entries over
// CONFIRM consecutive samples, applies exit hysteresis, and queues BUY/SELL
// events for a ready/valid consumer.
module rsi_signal_gen
    import rsi_pkg::*;
#(
    parameter int unsigned OB_TH   = DEF_OB_TH,
    parameter int unsigned OS_TH   = DEF_OS_TH,
    parameter int unsigned HYST    = DEF_HYST,
    parameter int unsigned CONFIRM = DEF_CONFIRM,
    parameter int unsigned QDEPTH  = DEF_QDEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rsi_in,
    input  logic       rsi_valid,
    output logic       sig_valid,
    input  logic       sig_ready,
    output logic [1:0] sig_code,
    output logic [7:0] sig_rsi,
    output logic [1:0] zone,
    output logic       overflow
);

    localparam logic [7:0] OB_LVL    = 8'(OB_TH);
    localparam logic [7:0] OS_LVL    = 8'(OS_TH);
    localparam logic [7:0] OS_EXIT   = 8'(OS_TH + HYST);
    localparam logic [7:0] OB_EXIT   = 8'(OB_TH - HYST);
    localparam logic [3:0] CONFIRM_C = 4'(CONFIRM);
    localparam bit         ONE_SHOT  = (CONFIRM == 1);

    state_e     state, state_nxt;
    zone_e      zone_q;
    logic [3:0] cnt, cnt_nxt, cnt_inc;
    logic [7:0] sample;
    logic       is_os, is_ob, go_os, go_ob;
    logic       push;
    evt_t       push_evt;
    logic [EVT_W-1:0] head_data;

    // Next-state, pending count and event push for the current sample.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        push          = 1'b0;
        push_evt.code = EVT_NONE;
        sample        = clamp_rsi(rsi_in);
        push_evt.rsi  = sample;
        is_os         = (sample <= OS_LVL);
        is_ob         = (sample >= OB_LVL);
        cnt_inc       = cnt + 4'd1;
        go_os         = 1'b0;
        go_ob         = 1'b0;
        if (rsi_valid) begin
            case (state)
                ST_NEUTRAL: begin
                    if (is_os)      go_os = 1'b1;
                    else if (is_ob) go_ob = 1'b1;
                end
                ST_OS_PEND: begin
                    if (is_os) begin
                        if (cnt_inc == CONFIRM_C) begin
                            state_nxt     = ST_OVERSOLD;
                            cnt_nxt       = '0;
                            push          = 1'b1;
                            push_evt.code = EVT_BUY;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else if (is_ob) begin
                        go_ob = 1'b1;
                    end else begin
                        state_nxt = ST_NEUTRAL;
                        cnt_nxt   = '0;
                    end
                end
                ST_OB_PEND: begin
                    if (is_ob) begin
                        if (cnt_inc == CONFIRM_C) begin
                            state_nxt     = ST_OVERBOUGHT;
                            cnt_nxt       = '0;
                            push          = 1'b1;
                            push_evt.code = EVT_SELL;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else if (is_os) begin
                        go_os = 1'b1;
                    end else begin
                        state_nxt = ST_NEUTRAL;
                        cnt_nxt   = '0;
                    end
                end
                ST_OVERSOLD: begin
                    if (is_ob)                  go_ob = 1'b1;
                    else if (sample >= OS_EXIT) state_nxt = ST_NEUTRAL;
                end
                ST_OVERBOUGHT: begin
                    if (is_os)                  go_os = 1'b1;
                    else if (sample <= OB_EXIT) state_nxt = ST_NEUTRAL;
                end
                default: begin
                    state_nxt = ST_NEUTRAL;
                    cnt_nxt   = '0;
                end
            endcase
        end
        // A fresh run toward a zone: confirm immediately when one sample suffices.
        if (go_os) begin
            if (ONE_SHOT) begin
                state_nxt     = ST_OVERSOLD;
                cnt_nxt       = '0;
                push          = 1'b1;
                push_evt.code = EVT_BUY;
            end else begin
                state_nxt = ST_OS_PEND;
                cnt_nxt   = 4'd1;
            end
        end else if (go_ob) begin
            if (ONE_SHOT) begin
                state_nxt     = ST_OVERBOUGHT;
                cnt_nxt       = '0;
                push          = 1'b1;
                push_evt.code = EVT_SELL;
            end else begin
                state_nxt = ST_OB_PEND;
                cnt_nxt   = 4'd1;
            end
        end
    end

    // FSM state, pending count and registered zone output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_NEUTRAL;
            cnt    <= '0;
            zone_q <= ZONE_NEUTRAL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            case (state_nxt)
                ST_OVERSOLD:   zone_q <= ZONE_OVERSOLD;
                ST_OVERBOUGHT: zone_q <= ZONE_OVERBOUGHT;
                default:       zone_q <= ZONE_NEUTRAL;
            endcase
        end
    end

    rsi_evt_queue #(
        .DEPTH (QDEPTH),
        .W     (EVT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_evt),
        .pop        (sig_ready),
        .head_valid (sig_valid),
        .head_data  (head_data),
        .overflow   (overflow)
    );

    assign zone     = zone_q;
    assign sig_code = head_data[9:8];
    assign sig_rsi  = head_data[7:0];

endmodule

// File: tb/tb_rsi_signal_gen.sv
// Self-checking bench for rsi_signal_gen: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_rsi_signal_gen;

    localparam int OB = 70;
    localparam int OS = 30;
    localparam int HY = 5;
    localparam int CF = 2;
    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rsi_in;
    logic       rsi_valid;
    logic       sig_ready;
    logic       sig_valid;
    logic [1:0] sig_code;
    logic [7:0] sig_rsi;
    logic [1:0] zone;
    logic       overflow;

    always #5 clk = ~clk;

    rsi_signal_gen #(
        .OB_TH   (OB),
        .OS_TH   (OS),
        .HYST    (HY),
        .CONFIRM (CF),
        .QDEPTH  (QD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rsi_in    (rsi_in),
        .rsi_valid (rsi_valid),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .sig_code  (sig_code),
        .sig_rsi   (sig_rsi),
        .zone      (zone),
        .overflow  (overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Behavioural model: zone (0 neutral, 1 oversold, 2 overbought), the
    // direction and length of the current run of qualifying samples, and the
    // event list as a queue of {code, rsi}.
    int         m_zone, m_dir, m_run;
    bit         m_ovf, m_push;
    logic [9:0] m_ev;
    logic [9:0] mq[$];

    function automatic void model_reset();
        m_zone = 0; m_dir = 0; m_run = 0; m_ovf = 0;
        mq.delete();
    endfunction

    function automatic void model_run(int d, int s);
        m_zone = 0;
        m_run  = (m_dir == d) ? m_run + 1 : 1;
        m_dir  = d;
        if (m_run >= CF) begin
            m_zone = (d < 0) ? 1 : 2;
            m_dir  = 0;
            m_run  = 0;
            m_push = 1;
            m_ev   = {((d < 0) ? 2'b01 : 2'b10), 8'(s)};
        end
    endfunction

    function automatic void model_eval(int raw);
        int s = (raw > 100) ? 100 : raw;
        bit lo = (s <= OS);
        bit hi = (s >= OB);
        case (m_zone)
            1: if (hi) model_run(1, s); else if (s >= OS + HY) m_zone = 0;
            2: if (lo) model_run(-1, s); else if (s <= OB - HY) m_zone = 0;
            default: begin
                if (lo)      model_run(-1, s);
                else if (hi) model_run(1, s);
                else begin m_dir = 0; m_run = 0; end
            end
        endcase
    endfunction

    function automatic void model_cycle(bit v, int s, bit r);
        bit popped = r && (mq.size() > 0);
        bit full   = (mq.size() == QD);
        if (popped) void'(mq.pop_front());
        m_push = 0;
        if (v) model_eval(s);
        if (m_push) begin
            if (!full || popped) mq.push_back(m_ev);
            else                 m_ovf = 1;
        end
    endfunction

    task automatic compare_all(input string tag);
        int ev = (mq.size() > 0) ? 1 : 0;
        int ec = ev ? int'(mq[0][9:8]) : 0;
        int er = ev ? int'(mq[0][7:0]) : 0;
        check({tag, ".valid"}, sig_valid, ev);
        check({tag, ".code"}, sig_code, ec);
        check({tag, ".rsi"}, sig_rsi, er);
        check({tag, ".zone"}, zone, m_zone);
        check({tag, ".ovf"}, overflow, int'(m_ovf));
    endtask

    // One clock: drive inputs away from the edge, advance the model, compare.
    task automatic cycle(input bit v, input int s, input bit r, input string tag);
        rsi_valid = v;
        rsi_in    = 8'(s);
        sig_ready = r;
        @(posedge clk);
        model_cycle(v, s, r);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".rst_valid"}, sig_valid, 0);
        check({tag, ".rst_code"}, sig_code, 0);
        check({tag, ".rst_rsi"}, sig_rsi, 0);
        check({tag, ".rst_zone"}, zone, 0);
        check({tag, ".rst_ovf"}, overflow, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int drain_code[4] = '{1, 2, 1, 2};
    int drain_rsi[4]  = '{20, 85, 12, 95};

    initial begin
        rst       = 1'b1;
        rsi_in    = '0;
        rsi_valid = 1'b0;
        sig_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("init");

        // BUY confirmed on the second oversold sample, visible one cycle later.
        cycle(1, 50, 1, "buy50");
        cycle(1, 25, 1, "buy25");
        cycle(1, 20, 1, "buy20");
        check("buy.code", sig_code, 1);
        check("buy.rsi", sig_rsi, 20);
        check("buy.zone", zone, 1);

        // Hysteresis: 33 stays oversold, 36 exits without an event.
        cycle(1, 33, 1, "hys33");
        check("hys33.zone", zone, 1);
        cycle(1, 36, 1, "hys36");
        check("hys36.zone", zone, 0);
        check("hys36.valid", sig_valid, 0);

        // Broken run restarts the count: 25,40,25 gives nothing, next 25 confirms.
        do_reset("pend");
        cycle(1, 25, 0, "pend25a");
        cycle(1, 40, 0, "pend40");
        cycle(1, 25, 0, "pend25b");
        check("pend.valid", sig_valid, 0);
        check("pend.zone", zone, 0);
        cycle(0, 99, 0, "pend_idle");
        cycle(1, 25, 0, "pend25c");
        check("pend.buy", sig_code, 1);

        // Clamping of out-of-range samples.
        do_reset("clamp");
        cycle(1, 200, 0, "clamp1");
        cycle(1, 200, 0, "clamp2");
        check("clamp.code", sig_code, 2);
        check("clamp.rsi", sig_rsi, 100);
        check("clamp.zone", zone, 2);

        // Five alternating events with no consumer: fifth is dropped.
        do_reset("ovf");
        cycle(1, 10, 0, "ovf_a"); cycle(1, 20, 0, "ovf_b");
        cycle(1, 90, 0, "ovf_c"); cycle(1, 85, 0, "ovf_d");
        cycle(1, 15, 0, "ovf_e"); cycle(1, 12, 0, "ovf_f");
        cycle(1, 75, 0, "ovf_g"); cycle(1, 95, 0, "ovf_h");
        check("ovf.before", overflow, 0);
        cycle(1, 5, 0, "ovf_i");  cycle(1, 3, 0, "ovf_j");
        check("ovf.flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.code", i), sig_code, drain_code[i]);
            check($sformatf("drain%0d.rsi", i), sig_rsi, drain_rsi[i]);
            cycle(0, 0, 1, $sformatf("drain%0d", i));
        end
        check("drain.empty", sig_valid, 0);

        // Asynchronous reset with two events queued and a zone active.
        do_reset("mid");
        cycle(1, 10, 0, "mid_a"); cycle(1, 20, 0, "mid_b");
        cycle(1, 90, 0, "mid_c"); cycle(1, 85, 0, "mid_d");
        check("mid.zone_before", zone, 2);
        do_reset("mid_rst");

        // Randomized traffic biased toward the thresholds, with varying backpressure.
        for (int i = 0; i < 800; i++) begin
            int  r = $urandom_range(0, 9);
            int  s;
            bit  v = ($urandom_range(0, 9) < 7);
            bit  rd;
            if (r < 3)      s = $urandom_range(0, 38);
            else if (r < 6) s = $urandom_range(62, 255);
            else            s = $urandom_range(0, 255);
            if ((i / 60) % 2 == 0) rd = ($urandom_range(0, 3) != 0);
            else                   rd = ($urandom_range(0, 5) == 0);
            if (i == 400) do_reset("rnd_rst");
            cycle(v, s, rd, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
